// File: rtl/ff_stim_sequencer.sv
// Stimulus sequencer for the lab flip-flop block: walks the 8-row SR table, toggles D,
// and publishes expected Q per row. Define FF_STIM_CHECK_EN to add the built-in Q grader.
module ff_stim_sequencer #(
    parameter int unsigned HOLD      = 1,
    parameter int unsigned D_TOGGLES = 3,
    parameter int unsigned D_PAUSE   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef FF_STIM_CHECK_EN
    input  logic       q_in,
    output logic       err,
    output logic [7:0] err_cnt,
`endif
    output logic       r,
    output logic       s,
    output logic       d,
    output logic [2:0] row,
    output logic       exp_q,
    output logic       exp_valid,
    output logic       busy,
    output logic       done
);

    localparam int unsigned CNT_W = 8;
    localparam int unsigned ROW_W = 3;
    localparam int unsigned PH_N  = D_TOGGLES + D_PAUSE;
    localparam int unsigned PH_W  = (PH_N > 1) ? $clog2(PH_N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   hold_cnt, hold_cnt_d;
    logic [PH_W-1:0]    phase, phase_d;
    logic               drain_cnt, drain_cnt_d;
    logic [ROW_W-1:0]   row_d;
    logic               r_d, s_d, d_d, exp_q_d, exp_valid_d, busy_d, done_d;
    logic [3:0]         entry;

    // Row table as {r, s, exp_q, exp_valid}; rows 6/7 drive R=S=1 and are not gradable.
    function automatic logic [3:0] row_entry(input logic [ROW_W-1:0] idx);
        case (idx)
            3'd0:    return 4'b1001;
            3'd1:    return 4'b0001;
            3'd2:    return 4'b0111;
            3'd3:    return 4'b0011;
            3'd4:    return 4'b0111;
            3'd5:    return 4'b1001;
            default: return 4'b1100;
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            hold_cnt  <= '0;
            phase     <= '0;
            drain_cnt <= 1'b0;
            r         <= 1'b1;
            s         <= 1'b0;
            d         <= 1'b0;
            row       <= '0;
            exp_q     <= 1'b0;
            exp_valid <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state     <= state_d;
            hold_cnt  <= hold_cnt_d;
            phase     <= phase_d;
            drain_cnt <= drain_cnt_d;
            r         <= r_d;
            s         <= s_d;
            d         <= d_d;
            row       <= row_d;
            exp_q     <= exp_q_d;
            exp_valid <= exp_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    always_comb begin
        state_d     = state;
        hold_cnt_d  = hold_cnt;
        phase_d     = phase;
        drain_cnt_d = drain_cnt;
        row_d       = row;
        d_d         = d;
        done_d      = 1'b0;
        r_d         = 1'b1;
        s_d         = 1'b0;
        exp_q_d     = 1'b0;
        exp_valid_d = 1'b1;
        busy_d      = 1'b0;
        entry       = 4'b0000;

        case (state)
            IDLE: begin
                if (start) begin
                    state_d    = RUN;
                    hold_cnt_d = '0;
                    row_d      = '0;
                end
            end
            RUN: begin
                if (hold_cnt == CNT_W'(HOLD - 1)) begin
                    hold_cnt_d = '0;
                    if (row == ROW_W'(7)) begin
                        state_d     = DRAIN;
                        drain_cnt_d = 1'b0;
                    end else begin
                        row_d = row + 3'd1;
                    end
                end else begin
                    hold_cnt_d = hold_cnt + 8'd1;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_d     = IDLE;
                    drain_cnt_d = 1'b0;
                    row_d       = '0;
                end else begin
                    drain_cnt_d = 1'b1;
                    done_d      = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // D bursts: toggle while phase is inside the toggle window, then pause.
        if (state != IDLE) begin
            if (32'(phase) < D_TOGGLES) begin
                d_d = ~d;
            end
            if (32'(phase) + 32'd1 >= PH_N) begin
                phase_d = '0;
            end else begin
                phase_d = phase + PH_W'(1);
            end
        end
        if (state_d == IDLE) begin
            d_d     = 1'b0;
            phase_d = '0;
        end

        entry = row_entry(row_d);
        case (state_d)
            RUN: begin
                {r_d, s_d, exp_q_d, exp_valid_d} = entry;
                busy_d = 1'b1;
            end
            DRAIN: begin
                exp_valid_d = 1'b0;
                busy_d      = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef FF_STIM_CHECK_EN
    logic       row_end_c;
    logic       grade_en, grade_exp_q, grade_exp_v;
    logic       err_d;
    logic [7:0] err_cnt_d;

    // Row r's last cycle is flagged, captured at t_r+HOLD, and graded against Q at t_r+HOLD+1.
    assign row_end_c = (state == RUN) && (hold_cnt == CNT_W'(HOLD - 1));

    always_comb begin
        err_d     = grade_en && grade_exp_v && (q_in != grade_exp_q);
        err_cnt_d = err_cnt;
        if ((state == IDLE) && start) begin
            err_cnt_d = '0;
        end else if (err_d && (err_cnt != 8'hFF)) begin
            err_cnt_d = err_cnt + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            grade_en    <= 1'b0;
            grade_exp_q <= 1'b0;
            grade_exp_v <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
        end else begin
            grade_en    <= row_end_c;
            grade_exp_q <= exp_q;
            grade_exp_v <= exp_valid;
            err         <= err_d;
            err_cnt     <= err_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_ff_stim_sequencer.sv
// Directed bench for ff_stim_sequencer: HOLD=1 instance for table/D/abort checks, HOLD=3 for row hold.
// Checker-port tests are included when FF_STIM_CHECK_EN is defined.
module tb_ff_stim_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic       rst1, start1, r1, s1, d1, eq1, ev1, busy1, done1;
    logic [2:0] row1;
    logic       rst3, start3, r3, s3, d3, eq3, ev3, busy3, done3;
    logic [2:0] row3;

`ifdef FF_STIM_CHECK_EN
    logic       q1_model = 1'b0;
    logic       q3_model = 1'b0;
    logic       q1_force0 = 1'b0;
    logic       q1_in, q3_in, err1, err3;
    logic [7:0] ecnt1, ecnt3;

    function automatic logic sr_next(input logic q, input logic rr, input logic ss);
        if (rr && !ss) return 1'b0;
        if (ss && !rr) return 1'b1;
        if (rr && ss)  return 1'b0;
        return q;
    endfunction

    // Ideal SR flip-flops sitting downstream of each sequencer.
    always @(posedge clk) q1_model <= sr_next(q1_model, r1, s1);
    always @(posedge clk) q3_model <= sr_next(q3_model, r3, s3);
    assign q1_in = q1_force0 ? 1'b0 : q1_model;
    assign q3_in = q3_model;
`endif

    ff_stim_sequencer #(.HOLD(1), .D_TOGGLES(3), .D_PAUSE(2)) u_dut1 (
        .clk(clk), .rst(rst1), .start(start1),
`ifdef FF_STIM_CHECK_EN
        .q_in(q1_in), .err(err1), .err_cnt(ecnt1),
`endif
        .r(r1), .s(s1), .d(d1), .row(row1), .exp_q(eq1), .exp_valid(ev1),
        .busy(busy1), .done(done1)
    );

    ff_stim_sequencer #(.HOLD(3), .D_TOGGLES(3), .D_PAUSE(2)) u_dut3 (
        .clk(clk), .rst(rst3), .start(start3),
`ifdef FF_STIM_CHECK_EN
        .q_in(q3_in), .err(err3), .err_cnt(ecnt3),
`endif
        .r(r3), .s(s3), .d(d3), .row(row3), .exp_q(eq3), .exp_valid(ev3),
        .busy(busy3), .done(done3)
    );

    logic [9:0] o1;
    logic [8:0] o3;
    assign o1 = {r1, s1, d1, row1, eq1, ev1, busy1, done1};
    assign o3 = {r3, s3, row3, eq3, ev3, busy3, done3};

    localparam logic [9:0] IDLE1 = 10'b10_0_000_0_1_0_0;
    localparam logic [8:0] IDLE3 = 9'b10_000_0_1_0_0;

    logic [1:0] rs_tab [8] = '{2'b10, 2'b00, 2'b01, 2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic       q_tab  [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       v_tab  [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       d_tab  [10] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Expected HOLD=1 outputs after edge k of a pass (k=0 is the START edge).
    function automatic logic [9:0] pass_vec(input int k);
        if (k < 8) return {rs_tab[k], d_tab[k], 3'(k), q_tab[k], v_tab[k], 1'b1, 1'b0};
        return {2'b10, d_tab[k], 3'd7, 1'b0, 1'b0, 1'b1, (k == 9)};
    endfunction

    function automatic logic [8:0] pass3_vec(input int k);
        if (k < 24) return {rs_tab[k/3], 3'(k/3), q_tab[k/3], v_tab[k/3], 1'b1, 1'b0};
        if (k < 26) return {2'b10, 3'd7, 1'b0, 1'b0, 1'b1, (k == 25)};
        return IDLE3;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int busy_cycles;

    initial begin
        rst1 = 1'b1; rst3 = 1'b1; start1 = 1'b0; start3 = 1'b0;

        // Reset and idle
        for (int i = 0; i < 2; i++) begin
            tick();
            chk($sformatf("rst1_%0d", i), 16'(o1), 16'(IDLE1));
            chk($sformatf("rst3_%0d", i), 16'(o3), 16'(IDLE3));
        end
`ifdef FF_STIM_CHECK_EN
        chk("rst_err", 16'({err1, ecnt1}), 16'd0);
`endif
        rst1 = 1'b0; rst3 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("idle1_%0d", i), 16'(o1), 16'(IDLE1));
            chk($sformatf("idle3_%0d", i), 16'(o3), 16'(IDLE3));
        end

        // Pass 1: START pulse, ideal flip-flop on q_in
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("p1_e0", 16'(o1), 16'(pass_vec(0)));
        for (int k = 1; k < 10; k++) begin
            tick();
            chk($sformatf("p1_e%0d", k), 16'(o1), 16'(pass_vec(k)));
`ifdef FF_STIM_CHECK_EN
            chk($sformatf("p1_err_e%0d", k), 16'(err1), 16'd0);
`endif
        end
        tick();
        chk("p1_e10", 16'(o1), 16'(IDLE1));
`ifdef FF_STIM_CHECK_EN
        chk("p1_ecnt", 16'(ecnt1), 16'd0);
        q1_force0 = 1'b1;
`endif

        // Pass 2: START held high throughout (ignored while busy), q_in stuck at 0
        start1 = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick();
            chk($sformatf("p2_e%0d", k), 16'(o1), 16'(pass_vec(k)));
`ifdef FF_STIM_CHECK_EN
            chk($sformatf("p2_err_e%0d", k), 16'(err1), 16'((k >= 4) && (k <= 6)));
            chk($sformatf("p2_ecnt_e%0d", k), 16'(ecnt1),
                16'((k < 4) ? 0 : (k == 4) ? 1 : (k == 5) ? 2 : 3));
`endif
        end
        tick();
        chk("p2_e10", 16'(o1), 16'(IDLE1));
`ifdef FF_STIM_CHECK_EN
        chk("p2_ecnt_hold", 16'(ecnt1), 16'd3);
`endif
        tick();
        chk("p3_restart_e0", 16'(o1), 16'(pass_vec(0)));
`ifdef FF_STIM_CHECK_EN
        chk("p3_ecnt_clr", 16'(ecnt1), 16'd0);
        q1_force0 = 1'b0;
`endif
        start1 = 1'b0;

        // Pass 3: START at ROW=3 ignored, RST at ROW=4 aborts
        for (int k = 1; k < 4; k++) begin
            tick();
            chk($sformatf("p3_e%0d", k), 16'(o1), 16'(pass_vec(k)));
        end
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("p3_ignore_e4", 16'(o1), 16'(pass_vec(4)));
        rst1 = 1'b1;
        tick();
        rst1 = 1'b0;
        chk("p3_abort", 16'(o1), 16'(IDLE1));
        tick();
        chk("p3_no_done", 16'(o1), 16'(IDLE1));

        // Pass 4: restart after abort runs to completion
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("p4_e0", 16'(o1), 16'(pass_vec(0)));
        for (int k = 1; k < 10; k++) begin
            tick();
            chk($sformatf("p4_e%0d", k), 16'(o1), 16'(pass_vec(k)));
        end
        tick();
        chk("p4_e10", 16'(o1), 16'(IDLE1));
`ifdef FF_STIM_CHECK_EN
        chk("p4_ecnt", 16'(ecnt1), 16'd0);
`endif

        // HOLD=3 pass: each row held 3 cycles, BUSY high 26 cycles
        busy_cycles = 0;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        for (int k = 0; k < 27; k++) begin
            if (k > 0) tick();
            if (busy3) busy_cycles++;
            chk($sformatf("h3_e%0d", k), 16'(o3), 16'(pass3_vec(k)));
        end
        chk("h3_busy_len", 16'(busy_cycles), 16'd26);
`ifdef FF_STIM_CHECK_EN
        chk("h3_ecnt", 16'(ecnt3), 16'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ff_stim_sequencer.md
Name: ff_stim_sequencer

Overview:
- Stimulus sequencer that sits directly upstream of the lab flip-flop schematic block and drives its R, S and D inputs.
- Walks the 8-row SR transition-table sequence in hardware, one row per HOLD clock cycles.
- Generates the D toggle pattern in parallel.
- Publishes the expected Q for each row and the row index so a downstream checker, or the built-in checker, can grade the flip-flop.

Parameters:
- HOLD, 1, clock cycles each row is held (1..255).
- D_TOGGLES, 3, consecutive cycles in which D toggles.
- D_PAUSE, 2, cycles D holds after each toggle burst.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- START  in  1  begin one pass; sampled in IDLE only.
- R  out  1  reset input to the flip-flop under test.
- S  out  1  set input to the flip-flop under test.
- D  out  1  data input to the D flip-flop under test.
- ROW  out  3  index of the row currently driven (0..7).
- EXP_Q  out  1  expected Q after the current row.
- EXP_VALID  out  1  0 for rows 6 and 7 (R=S=1, indeterminate).
- BUSY  out  1  high in RUN and DRAIN.
- DONE  out  1  one-cycle pulse at end of pass.

Behaviour:
- Clock and reset: one clock, CLK; reset is synchronous and active-high (RST); outputs and state are registered.
- Reset values: state=IDLE, R=1, S=0, D=0, ROW=0, EXP_Q=0, EXP_VALID=1, BUSY=0, DONE=0, hold count=0, D phase=0.
- RST mid-run aborts immediately to the reset values; no DONE pulse.
- States: IDLE, RUN, DRAIN.
- IDLE: outputs at reset values.
  - START=1 -> RUN; at that edge ROW=0, R/S=row 0, D=0, D phase=0, BUSY=1.
- RUN: hold count increments each edge.
  - At count HOLD-1 the count clears and ROW increments.
  - On the last cycle of row 7, go to DRAIN.
- Row table, as (R,S,EXP_Q,EXP_VALID):
  - 0: 1,0,0,1
  - 1: 0,0,0,1
  - 2: 0,1,1,1
  - 3: 0,0,1,1
  - 4: 0,1,1,1
  - 5: 1,0,0,1
  - 6: 1,1,0,0
  - 7: 1,1,0,0
- DRAIN: exactly 2 cycles.
  - R=1, S=0, ROW stays 7, EXP_VALID=0.
  - DONE=1 during the second DRAIN cycle, then IDLE.
- Pass length: BUSY high for 8*HOLD+2 cycles.
- START while BUSY: ignored. START held high in IDLE after DONE: a new pass starts on the next edge.
- D generator (RUN and DRAIN only):
  - At each edge after the START edge, if phase < D_TOGGLES then D toggles.
  - Phase increments modulo D_TOGGLES+D_PAUSE.
  - D is forced to 0 in IDLE.
- Row r's effect on Q is graded at edge t_r+HOLD+1, where t_r is the edge at which row r was first driven. This allows one edge for the flip-flop to capture the row and one cycle for Q to settle.

Optional Feature:
- Macro: FF_STIM_CHECK_EN.
- Defined: adds the following ports.
  - Q_IN  in  1  flip-flop Q.
  - ERR  out  1  one-cycle pulse on a mismatch.
  - ERR_CNT  out  8  saturating mismatch count.
- Checker behaviour:
  - Holds a 2-stage delayed copy of the row-end flag, EXP_Q and EXP_VALID.
  - At each grading edge with EXP_VALID=1 and Q_IN != EXP_Q: ERR=1 for one cycle and ERR_CNT+1, saturating at 255.
  - ERR_CNT clears on RST and on an accepted START; it holds its value in IDLE.
- Undefined: ports absent, no checker logic; the sequencer behaves identically.

Test Plan (HOLD=1, D_TOGGLES=3, D_PAUSE=2 unless stated):
- Reset/idle: RST=1 for 2 cycles, then START=0 for 5 cycles -> R=1, S=0, D=0, BUSY=0, DONE=0 throughout.
- Full pass: START pulse at edge 0 -> (R,S) at edges 0..7 = 10,00,01,00,01,10,11,11; ROW=0..7; R=1,S=0 at edges 8,9; DONE high only after edge 9; BUSY low after edge 10.
- D pattern: same pass -> D after edges 0..9 = 0,1,0,1,1,1,0,1,0,0.
- HOLD=3: START -> each row held exactly 3 cycles; BUSY high 26 cycles; one DONE pulse.
- Abort and ignore: START during RUN at ROW=3 -> ignored, sequence unchanged; RST asserted at ROW=4 -> next cycle IDLE values, no DONE; a following START restarts at ROW=0.
- FF_STIM_CHECK_EN: model Q_IN as an ideal SR flip-flop -> ERR_CNT=0 after DONE. Force Q_IN=0 permanently -> ERR pulses at edges 4,5,6 (rows 2,3,4) and ERR_CNT=3. Rows 6 and 7 are never counted.
